// File: rtl/blake2_pkg.sv
// blake2_pkg: shared Blake2b constants, digest entry type and length/keep helpers.
package blake2_pkg;
    localparam int BLAKE2B_DIGEST_BITS = 512;
    localparam int BLAKE2B_MAX_BYTES   = 64;

    typedef struct packed {
        logic [BLAKE2B_DIGEST_BITS-1:0] digest;
        logic [6:0]                     nn;
    } digest_entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    function automatic logic [6:0] norm_bytes(input logic [6:0] req, input int max_bytes);
        return (req == 7'd0 || int'(req) > max_bytes) ? 7'(max_bytes) : req;
    endfunction

    function automatic logic [6:0] word_count(input logic [6:0] nn, input int bus_bytes);
        return 7'((int'(nn) + bus_bytes - 1) / bus_bytes);
    endfunction

    // Callers truncate the 64-bit result to their own bus byte count.
    function automatic logic [63:0] keep_mask(input logic [6:0] nn, input int bus_bytes, input logic last);
        int rem = int'(nn) % bus_bytes;
        return (last && rem != 0) ? (64'd1 << rem) - 64'd1 : (64'd1 << bus_bytes) - 64'd1;
    endfunction
endpackage

// File: rtl/digest_fifo2.sv
// digest_fifo2: two-entry FIFO with a registered head; push and pop may coincide.
module digest_fifo2
    import blake2_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    occ_t         state, state_n;
    logic [W-1:0] tail;
    logic         wr_head, wr_tail;

    always_comb begin
        state_n = state;
        if (push && !pop) state_n = state == EMPTY ? ONE : FULL;
        else if (pop && !push) state_n = state == FULL ? ONE : EMPTY;
    end

    assign wr_head = push && (state == EMPTY || (pop && state == ONE));
    assign wr_tail = push && (state == ONE ? !pop : state == FULL);
    assign full    = state == FULL;
    assign empty   = state == EMPTY;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_n;
            if (pop && state == FULL) head <= tail;
            else if (wr_head) head <= din;
            if (wr_tail) tail <= din;
        end
    end
endmodule

// File: rtl/blake2_digest_serializer.sv
// blake2_digest_serializer: buffers Blake2 digests and streams them as BUS_WIDTH-bit words.
// Define DIGEST_BYTE_SWAP_EN for byte-reversed (big-endian) words with mirrored keep.
module blake2_digest_serializer
    import blake2_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int DIGEST_WIDTH = BLAKE2B_DIGEST_BITS,
    parameter int MAX_BYTES    = DIGEST_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIGEST_WIDTH-1:0] digest,
    input  logic                    digest_valid,
    input  logic [6:0]              digest_bytes,
    output logic                    digest_ready,
    output logic [BUS_WIDTH-1:0]    dout,
    output logic [BUS_WIDTH/8-1:0]  dout_keep,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    overflow
);
    localparam int BB = BUS_WIDTH / 8;
    localparam int EW = DIGEST_WIDTH + 7;

    logic [EW-1:0]           head;
    logic [DIGEST_WIDTH-1:0] head_digest;
    logic [6:0]              head_nn, k;
    logic [BUS_WIDTH-1:0]    word, masked, ordered;
    logic [BB-1:0]           keep, keep_ordered;
    logic                    full, empty, last, xfer, pop, push;

    digest_fifo2 #(.W(EW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({digest, norm_bytes(digest_bytes, MAX_BYTES)}),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign head_digest  = head[EW-1:7];
    assign head_nn      = head[6:0];
    assign last         = k == word_count(head_nn, BB) - 7'd1;
    assign xfer         = !empty && dout_ready;
    assign pop          = xfer && last;
    assign digest_ready = !full || pop;
    assign push         = digest_valid && digest_ready;
    assign word         = head_digest[BUS_WIDTH*k +: BUS_WIDTH];
    assign keep         = BB'(keep_mask(head_nn, BB, last));

    for (genvar j = 0; j < BB; j++) begin : g_byte
        assign masked[8*j +: 8] = keep[j] ? word[8*j +: 8] : 8'h00;
`ifdef DIGEST_BYTE_SWAP_EN
        assign ordered[8*j +: 8] = masked[8*(BB-1-j) +: 8];
        assign keep_ordered[j]   = keep[BB-1-j];
`else
        assign ordered[8*j +: 8] = masked[8*j +: 8];
        assign keep_ordered[j]   = keep[j];
`endif
    end

    assign dout       = empty ? '0 : ordered;
    assign dout_keep  = empty ? '0 : keep_ordered;
    assign dout_valid = !empty;
    assign dout_last  = !empty && last;

    always_ff @(posedge clk) begin
        if (reset) begin
            k        <= '0;
            overflow <= 1'b0;
        end else begin
            if (xfer) k <= last ? 7'd0 : k + 7'd1;
            if (digest_valid && !digest_ready) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_blake2_digest_serializer.sv
// tb_blake2_digest_serializer: directed checks of capture, truncation, stalls, overflow and reset.
module tb_blake2_digest_serializer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] digest = '0;
    logic         digest_valid = 1'b0;
    logic [6:0]   digest_bytes = '0;
    logic         digest_ready;
    logic [31:0]  dout;
    logic [3:0]   dout_keep;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         dout_last;
    logic         overflow;
    int           checks = 0;
    int           errors = 0;

    blake2_digest_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_bytes (digest_bytes),
        .digest_ready (digest_ready),
        .dout         (dout),
        .dout_keep    (dout_keep),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pattern(input int base);
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(base + i);
        return d;
    endfunction

    function automatic logic [31:0] exp_word(input int base, input int nn, input int k);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) if (4*k + j < nn) w[8*j +: 8] = 8'(base + 4*k + j);
        return w;
    endfunction

    function automatic logic [3:0] exp_keep(input int nn, input int k);
        logic [3:0] m = '0;
        for (int j = 0; j < 4; j++) m[j] = (4*k + j < nn);
        return m;
    endfunction

    task automatic send(input int base, input int req);
        digest       = pattern(base);
        digest_bytes = 7'(req);
        digest_valid = 1'b1;
        step();
        digest_valid = 1'b0;
    endtask

    // Streams one digest; nn is the normalised length, last_w/last_k hand-computed final word.
    task automatic drain(input string tag, input int base, input int nn, input int nw,
                         input bit toggle, input logic [31:0] last_w, input logic [3:0] last_k);
        int k = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] pd = '0;
        logic [3:0]  pk = '0;
        logic        pl = 1'b0;
        while (k < nw && cyc < 200) begin
            dout_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            check($sformatf("%s valid c%0d", tag, cyc), 64'(dout_valid), 64'd1);
            if (stalled) check($sformatf("%s hold k%0d", tag, k), {dout_last, dout_keep, dout}, {pl, pk, pd});
            check($sformatf("%s dout k%0d", tag, k), 64'(dout), 64'(exp_word(base, nn, k)));
            check($sformatf("%s keep k%0d", tag, k), 64'(dout_keep), 64'(exp_keep(nn, k)));
            check($sformatf("%s last k%0d", tag, k), 64'(dout_last), 64'(k == nw - 1));
            if (k == nw - 1) check({tag, " final"}, {dout_keep, dout}, {last_k, last_w});
            stalled = !dout_ready;
            {pl, pk, pd} = {dout_last, dout_keep, dout};
            if (dout_ready) k++;
            step();
            cyc++;
        end
        check({tag, " words"}, 64'(k), 64'(nw));
    endtask

    initial begin
        step();
        step();
        check("rst valid", 64'(dout_valid), 64'd0);
        check("rst ready", 64'(digest_ready), 64'd1);
        check("rst ovf", 64'(overflow), 64'd0);
        check("rst outs", {dout_last, dout_keep, dout}, '0);
        reset = 1'b0;
        step();

        send(0, 64);
        check("latency w0", 64'(dout), 64'h03020100);
        drain("n64", 0, 64, 16, 0, 32'h3F3E3D3C, 4'hF);
        check("n64 empty", {dout_valid, dout_last, dout_keep, dout}, '0);

        send(0, 20);
        drain("n20", 0, 20, 5, 0, 32'h13121110, 4'hF);
        send(0, 21);
        drain("n21", 0, 21, 6, 0, 32'h00000014, 4'h1);
        send(0, 0);
        drain("n0", 0, 64, 16, 0, 32'h3F3E3D3C, 4'hF);
        send(0, 100);
        drain("n100", 0, 64, 16, 0, 32'h3F3E3D3C, 4'hF);

        send(0, 64);
        drain("toggle", 0, 64, 16, 1, 32'h3F3E3D3C, 4'hF);

        dout_ready   = 1'b0;
        digest       = pattern(8'h40);
        digest_bytes = 7'd8;
        digest_valid = 1'b1;
        step();
        digest = pattern(8'h80);
        check("ovf ready1", 64'(digest_ready), 64'd1);
        step();
        digest = pattern(8'hC0);
        check("ovf ready0", 64'(digest_ready), 64'd0);
        step();
        digest_valid = 1'b0;
        check("ovf set", 64'(overflow), 64'd1);
        check("ovf head", 64'(dout), 64'h43424140);
        drain("ovf d1", 8'h40, 8, 2, 0, 32'h47464544, 4'hF);
        drain("ovf d2", 8'h80, 8, 2, 0, 32'h87868584, 4'hF);
        check("ovf drop", 64'(dout_valid), 64'd0);
        check("ovf held", 64'(overflow), 64'd1);

        send(0, 64);
        dout_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("mid w7", 64'(dout), 64'h1F1E1D1C);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid valid", 64'(dout_valid), 64'd0);
        check("mid ready", 64'(digest_ready), 64'd1);
        check("mid ovf", 64'(overflow), 64'd0);
        check("mid outs", {dout_last, dout_keep, dout}, '0);
        send(8'h10, 12);
        drain("restart", 8'h10, 12, 3, 0, 32'h1B1A1918, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
